// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble-serial add/subtract engine.
package nibble_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/nibble_addsub_cell.sv
// Combinational 4-bit add/subtract cell: sum = a + (b ^ {4{sel}}) + cin.
// o_c3 is the carry into bit 3, used for signed-overflow detection.
module nibble_addsub_cell
    import nibble_pkg::*;
(
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic             i_sel,
    input  logic             i_cin,
    output logic [NIB_W-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c3
);

    logic [NIB_W-1:0] w_bx;
    logic [NIB_W-1:0] w_lo;
    logic [NIB_W:0]   w_full;

    assign w_bx = i_b ^ {NIB_W{i_sel}};

    // Low three bits summed separately to expose the carry into the top bit
    assign w_lo   = {1'b0, i_a[NIB_W-2:0]} + {1'b0, w_bx[NIB_W-2:0]}
                  + {{(NIB_W-1){1'b0}}, i_cin};
    assign w_full = {1'b0, i_a} + {1'b0, w_bx} + {{NIB_W{1'b0}}, i_cin};

    assign o_sum  = w_full[NIB_W-1:0];
    assign o_cout = w_full[NIB_W];
    assign o_c3   = w_lo[NIB_W-1];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Serial WIDTH-bit add/subtract, one nibble per clock, LSB first, start/done handshake.
// Optional signed-overflow output enabled by defining OVERFLOW_FLAG_EN.
module nibble_serial_addsub
    import nibble_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned CNT_W = $clog2(NIB);

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sel;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_c_out;
`ifdef OVERFLOW_FLAG_EN
    logic             r_ovf;
`endif

    logic [NIB_W-1:0] w_sum;
    logic             w_cout;
    logic             w_c3;
    logic             w_last;

    nibble_addsub_cell u_cell (
        .i_a    (r_a[NIB_W-1:0]),
        .i_b    (r_b[NIB_W-1:0]),
        .i_sel  (r_sel),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_c3   (w_c3)
    );

    assign w_last = (r_cnt == CNT_W'(NIB - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= OP_ADD;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_c_out  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sel   <= sel;
                        // Subtract is a + ~b + 1: the +1 enters as the initial carry
                        r_carry <= sel;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_result <= {w_sum, r_result[WIDTH-1:NIB_W]};
                    r_a      <= r_a >> NIB_W;
                    r_b      <= r_b >> NIB_W;
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_c_out <= w_cout;
`ifdef OVERFLOW_FLAG_EN
                        r_ovf   <= w_c3 ^ w_cout;
`endif
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifndef OVERFLOW_FLAG_EN
    logic w_unused;
    assign w_unused = w_c3;
`endif

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign c_out  = r_c_out;
`ifdef OVERFLOW_FLAG_EN
    assign ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub: directed table, corner sequences, random ops.
module tb_nibble_serial_addsub;

    localparam int unsigned W    = 16;
    localparam int unsigned NIBS = W / 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    nibble_serial_addsub #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sel    (sel),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .c_out  (c_out)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsel;
        logic [W-1:0] exp_res;
        logic         exp_c;
        logic         exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width operands
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msel,
                         output logic [W-1:0] res, output logic c, output logic v);
        logic [W:0] full;
        logic [W-1:0] opb;
        opb  = msel ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, opb} + {{W{1'b0}}, msel};
        res  = full[W-1:0];
        c    = full[W];
        if (msel == 1'b0) v = (ma[W-1] == mb[W-1]) && (res[W-1] != ma[W-1]);
        else              v = (ma[W-1] != mb[W-1]) && (res[W-1] != ma[W-1]);
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the DONE->IDLE edge
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsel,
                          input logic [W-1:0] er, input logic ec, input logic ev,
                          input string tag);
        int cycles;
        int busy_cnt;
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        sel   = tsel;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        sel   = 1'($urandom);
        busy_cnt = busy ? 1 : 0;
        cycles   = 0;
        while (!done && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy) busy_cnt++;
        end
        check({tag, " latency"}, cycles, NIBS);
        check({tag, " busy_cycles"}, busy_cnt, NIBS + 1);
        check({tag, " result"}, result, er);
        check({tag, " c_out"}, c_out, ec);
`ifdef OVERFLOW_FLAG_EN
        check({tag, " ovf"}, ovf, ev);
`else
        if (ev === 1'bx) $display("note: unknown ovf expectation for %s", tag);
`endif
        @(posedge clk);
        #1;
        check({tag, " done_pulse_end"}, {busy, done}, 2'b00);
    endtask

    task automatic run_model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                             input logic tsel, input string tag);
        logic [W-1:0] er;
        logic ec;
        logic ev;
        model(ta, tb_v, tsel, er, ec, ev);
        run_op(ta, tb_v, tsel, er, ec, ev, tag);
    endtask

    vec_t vecs[7];
    logic [W-1:0] bnd[8];

    initial begin
        int cycles;
        int dones;

        vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};

        bnd = '{16'h0000, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'hFFFF, 16'h8000, 16'h7FFF};

        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset result", result, '0);
        check("reset c_out", c_out, 1'b0);
`ifdef OVERFLOW_FLAG_EN
        check("reset ovf", ovf, 1'b0);
`endif
        #11;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table, issued back-to-back
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vsel, vecs[i].exp_res, vecs[i].exp_c,
                   vecs[i].exp_ovf, $sformatf("vec%0d", i));
        end

        // Start while busy must be ignored
        start = 1'b1; a = 16'h0005; b = 16'h0007; sel = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1; a = 16'h1111; b = 16'h1111; sel = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("busy_start latency", cycles, NIBS - 2);
        check("busy_start result", result, 16'hFFFE);
        check("busy_start c_out", c_out, 1'b0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("busy_start extra_done", dones, 0);
        check("busy_start idle", busy, 1'b0);

        // Asynchronous reset in the second RUN cycle
        start = 1'b1; a = 16'h1234; b = 16'h4321; sel = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst busy", busy, 1'b0);
        check("midrst done", done, 1'b0);
        check("midrst result", result, '0);
        check("midrst c_out", c_out, 1'b0);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "post_rst");

        // Nibble-boundary operand pairs, both operations
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                for (int s = 0; s < 2; s++) begin
                    run_model(bnd[i], bnd[j], 1'(s), $sformatf("bnd%0d_%0d_%0d", i, j, s));
                end
            end
        end

        // Random operations
        for (int k = 0; k < 150; k++) begin
            run_model(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
